// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage with valid/ready on both
// sides, single-bubble load-use hazard insertion, synchronous flush and a
// saturating stall-cycle counter.
module decode_stage #(
    parameter int INSTR_W = 16,
    parameter int REG_AW  = 3,
    parameter int IMM_W   = 6,
    parameter int JUMP_W  = 8,
    parameter int SHAMT_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               out_ready,
    output logic               out_valid,
    input  logic               flush,
    output logic [3:0]         opcode,
    output logic [REG_AW-1:0]  wreg_sig,
    output logic [REG_AW-1:0]  rreg_sig1,
    output logic [REG_AW-1:0]  rreg_sig2,
    output logic [IMM_W-1:0]   imm,
    output logic [JUMP_W-1:0]  jump_addr,
    output logic [SHAMT_W-1:0] shamt,
    output logic               pc_select,
    output logic               alu_out_select,
    output logic               reg_write,
    output logic               rd_select,
    output logic               mul_flag,
    output logic [1:0]         src2_select,
    output logic [CNT_W-1:0]   stall_count
);

    localparam logic [3:0] OP_LI   = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_JUMP = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    // Pipeline register contents
    logic               valid_q;
    logic [3:0]         op_q;
    logic [REG_AW-1:0]  wreg_q, rs1_q, rs2_q;
    logic [IMM_W-1:0]   imm_q;
    logic [JUMP_W-1:0]  jaddr_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic               pcsel_q, aosel_q, rw_q, rdsel_q, mul_q;
    logic [1:0]         s2sel_q;
    logic [CNT_W-1:0]   cnt_q;

    // Incoming instruction fields and decoded controls
    logic [3:0]         op_d;
    logic [REG_AW-1:0]  wreg_d, rs1_d, rs2_d;
    logic [IMM_W-1:0]   imm_d;
    logic [JUMP_W-1:0]  jaddr_d;
    logic [SHAMT_W-1:0] shamt_d;
    logic               pcsel_d, aosel_d, rw_d, rdsel_d, mul_d;
    logic [1:0]         s2sel_d;
    logic               reads_rs1, reads_rs2;
    logic               hazard, capture, drain;
    logic [CNT_W-1:0]   cnt_d;

    assign op_d    = instr[3:0];
    assign wreg_d  = instr[4 +: REG_AW];
    assign rs1_d   = instr[4+REG_AW +: REG_AW];
    assign rs2_d   = instr[4+2*REG_AW +: REG_AW];
    assign imm_d   = instr[INSTR_W-1 -: IMM_W];
    assign jaddr_d = instr[4 +: JUMP_W];
    assign shamt_d = instr[INSTR_W-1 -: SHAMT_W];

    // Opcode-to-control decode of the incoming instruction
    always_comb begin
        pcsel_d   = (op_d == OP_JUMP);
        aosel_d   = (op_d == OP_LW);
        rdsel_d   = (op_d == OP_LI);
        mul_d     = (op_d == OP_MUL);
        rw_d      = !((op_d == OP_SW) || (op_d == OP_JUMP));
        s2sel_d   = 2'd0;
        if (op_d >= 4'd5 && op_d <= 4'd8)
            s2sel_d = 2'd1;
        else if (op_d == 4'd1 || op_d == 4'd2)
            s2sel_d = 2'd2;
        reads_rs1 = !((op_d == OP_LI) || (op_d == OP_JUMP));
        reads_rs2 = (op_d inside {4'd0, 4'd3, 4'd4, 4'd8}) || (op_d >= 4'd10);
    end

    // Load-use hazard: the lw in the stage writes a register the incoming instr reads
    always_comb begin
        hazard = valid_q && (op_q == OP_LW) && in_valid &&
                 ((reads_rs1 && (rs1_d == wreg_q)) || (reads_rs2 && (rs2_d == wreg_q)));
        in_ready = (!valid_q || out_ready) && !hazard && !flush;
        capture  = in_valid && in_ready;
        drain    = valid_q && out_ready;
        cnt_d    = cnt_q;
        if (hazard && !flush && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Pipeline register: reset > flush > capture > drain-to-bubble > hold
    always_ff @(posedge clk) begin
        if (!rst_n || flush || (drain && !capture)) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            wreg_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            jaddr_q <= '0;
            shamt_q <= '0;
            pcsel_q <= 1'b0;
            aosel_q <= 1'b0;
            rw_q    <= 1'b0;
            rdsel_q <= 1'b0;
            mul_q   <= 1'b0;
            s2sel_q <= 2'd0;
        end else if (capture) begin
            valid_q <= 1'b1;
            op_q    <= op_d;
            wreg_q  <= wreg_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            jaddr_q <= jaddr_d;
            shamt_q <= shamt_d;
            pcsel_q <= pcsel_d;
            aosel_q <= aosel_d;
            rw_q    <= rw_d;
            rdsel_q <= rdsel_d;
            mul_q   <= mul_d;
            s2sel_q <= s2sel_d;
        end
    end

    // Saturating stall-cycle counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign out_valid      = valid_q;
    assign opcode         = op_q;
    assign wreg_sig       = wreg_q;
    assign rreg_sig1      = rs1_q;
    assign rreg_sig2      = rs2_q;
    assign imm            = imm_q;
    assign jump_addr      = jaddr_q;
    assign shamt          = shamt_q;
    assign pc_select      = pcsel_q;
    assign alu_out_select = aosel_q;
    assign reg_write      = rw_q;
    assign rd_select      = rdsel_q;
    assign mul_flag       = mul_q;
    assign src2_select    = s2sel_q;
    assign stall_count    = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors, a slot-level reference model
// checked every cycle, and hand-computed literal expectations.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, flush;
    logic [15:0] instr;

    logic        in_ready, out_valid, pc_select, alu_out_select, reg_write, rd_select, mul_flag;
    logic [3:0]  opcode;
    logic [2:0]  wreg_sig, rreg_sig1, rreg_sig2, shamt;
    logic [5:0]  imm;
    logic [7:0]  jump_addr;
    logic [1:0]  src2_select;
    logic [15:0] stall_count;

    logic        s_in_ready, s_out_valid, s_pc, s_ao, s_rw, s_rd, s_mul;
    logic [3:0]  s_op;
    logic [2:0]  s_wr, s_r1, s_r2, s_sh;
    logic [5:0]  s_imm;
    logic [7:0]  s_ja;
    logic [1:0]  s_s2;
    logic [1:0]  s_cnt;

    always #5 clk = ~clk;

    decode_stage u_dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready), .out_valid(out_valid), .flush(flush), .opcode(opcode),
        .wreg_sig(wreg_sig), .rreg_sig1(rreg_sig1), .rreg_sig2(rreg_sig2), .imm(imm),
        .jump_addr(jump_addr), .shamt(shamt), .pc_select(pc_select),
        .alu_out_select(alu_out_select), .reg_write(reg_write), .rd_select(rd_select),
        .mul_flag(mul_flag), .src2_select(src2_select), .stall_count(stall_count)
    );

    decode_stage #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(s_in_ready),
        .out_ready(out_ready), .out_valid(s_out_valid), .flush(flush), .opcode(s_op),
        .wreg_sig(s_wr), .rreg_sig1(s_r1), .rreg_sig2(s_r2), .imm(s_imm),
        .jump_addr(s_ja), .shamt(s_sh), .pc_select(s_pc),
        .alu_out_select(s_ao), .reg_write(s_rw), .rd_select(s_rd),
        .mul_flag(s_mul), .src2_select(s_s2), .stall_count(s_cnt)
    );

    typedef struct packed {
        logic       v;
        logic [3:0] op;
        logic [2:0] wr, r1, r2;
        logic [5:0] imm;
        logic [7:0] ja;
        logic [2:0] sh;
        logic       pc, ao, rw, rd, mul;
        logic [1:0] s2;
    } out_t;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Spec-level expected outputs for a slot holding word w (or empty)
    function automatic out_t expect_out(input bit v, input logic [15:0] w);
        out_t e;
        int op;
        e = '0;
        if (!v) return e;
        op    = int'(w[3:0]);
        e.v   = 1'b1;
        e.op  = w[3:0];
        e.wr  = w[6:4];
        e.r1  = w[9:7];
        e.r2  = w[12:10];
        e.imm = w[15:10];
        e.ja  = w[11:4];
        e.sh  = w[15:13];
        e.pc  = (op == 9);
        e.ao  = (op == 7);
        e.rd  = (op == 6);
        e.mul = (op == 10);
        e.rw  = !(op == 8 || op == 9);
        case (op)
            5, 6, 7, 8: e.s2 = 2'd1;
            1, 2:       e.s2 = 2'd2;
            default:    e.s2 = 2'd0;
        endcase
        return e;
    endfunction

    // Reference model state: one slot plus an unbounded hazard-cycle tally
    bit          m_v = 0;
    logic [15:0] m_w = '0;
    int          m_hz = 0;
    bit          m_started = 0;

    function automatic bit model_hazard(input bit v, input logic [15:0] w,
                                        input bit iv, input logic [15:0] nw);
        int  op;
        bit  r1, r2;
        op = int'(nw[3:0]);
        r1 = !(op == 6 || op == 9);
        r2 = (op == 0 || op == 3 || op == 4 || op == 8 || op >= 10);
        return v && (w[3:0] == 4'd7) && iv &&
               ((r1 && nw[9:7] == w[6:4]) || (r2 && nw[12:10] == w[6:4]));
    endfunction

    function automatic bit model_ready();
        return (!m_v || out_ready) && !model_hazard(m_v, m_w, in_valid, instr) && !flush;
    endfunction

    always @(posedge clk) begin
        bit hz, rdy;
        if (!rst_n) begin
            m_v = 0; m_w = '0; m_hz = 0; m_started = 1;
        end else begin
            hz  = model_hazard(m_v, m_w, in_valid, instr);
            rdy = model_ready();
            if (hz && !flush) m_hz++;
            if (flush)                 m_v = 0;
            else if (in_valid && rdy)  begin m_v = 1; m_w = instr; end
            else if (m_v && out_ready) m_v = 0;
        end
    end

    out_t act;
    assign act = '{out_valid, opcode, wreg_sig, rreg_sig1, rreg_sig2, imm, jump_addr, shamt,
                   pc_select, alu_out_select, reg_write, rd_select, mul_flag, src2_select};

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_started) begin
            chk("model_outputs", act, expect_out(m_v, m_w));
            chk("model_in_ready", in_ready, model_ready());
            chk("model_stall_count", stall_count, m_hz);
            chk("model_stall_count_sat", s_cnt, (m_hz > 3) ? 3 : m_hz);
            chk("model_sat_outputs", {s_out_valid, s_op}, {m_v, m_v ? m_w[3:0] : 4'd0});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [15:0] w);
        in_valid = v;
        instr    = w;
        #1;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; out_ready = 1; flush = 0; instr = '0;
        cyc(); cyc();
        rst_n = 1; #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall", stall_count, 0);
        chk("rst_outputs", act, 0);

        // Streaming: sll then jump
        drive(1, 16'hA0A1); cyc();
        chk("sll_opcode", opcode, 1);
        chk("sll_src2", src2_select, 2);
        chk("sll_shamt", shamt, 5);
        chk("sll_rs1", rreg_sig1, 1);
        chk("sll_wreg", wreg_sig, 2);
        chk("sll_rw", reg_write, 1);
        drive(1, 16'h0A59); cyc();
        chk("jmp_pc", pc_select, 1);
        chk("jmp_addr", jump_addr, 8'hA5);
        chk("jmp_rw", reg_write, 0);
        drive(0, 16'h0000); cyc();
        chk("drain_bubble", out_valid, 0);

        // Load-use: lw r3 then add reading r3
        drive(1, 16'h14B7); cyc();
        chk("lw_ao", alu_out_select, 1);
        chk("lw_imm", imm, 5);
        drive(1, 16'h09C0);
        chk("lu_in_ready", in_ready, 0);
        cyc();
        chk("lu_bubble", out_valid, 0);
        chk("lu_stall", stall_count, 1);
        cyc();
        chk("lu_add_valid", out_valid, 1);
        chk("lu_add_wreg", wreg_sig, 4);
        drive(0, 16'h0000); cyc();

        // Backpressure holding lw
        drive(1, 16'h14B7); cyc();
        out_ready = 0;
        drive(1, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", in_ready, 0);
            cyc();
            chk("bp_hold_op", opcode, 7);
            chk("bp_hold_imm", imm, 5);
        end
        out_ready = 1; #1;
        chk("bp_release_ready", in_ready, 1);
        cyc();
        chk("bp_next_op", opcode, 1);
        drive(0, 16'h0000); cyc();

        // Flush with jump in stage
        drive(1, 16'h0A59); cyc();
        flush = 1;
        drive(1, 16'hA0A1);
        chk("fl_in_ready", in_ready, 0);
        cyc();
        chk("fl_valid", out_valid, 0);
        chk("fl_pc", pc_select, 0);
        flush = 0; drive(0, 16'h0000); cyc();

        // Flush under backpressure
        drive(1, 16'h0A59); cyc();
        out_ready = 0; flush = 1; drive(0, 16'h0000); cyc();
        chk("flbp_valid", out_valid, 0);
        flush = 0; out_ready = 1; cyc();

        // Saturation: lw held with dependent add waiting
        drive(1, 16'h14B7); cyc();
        out_ready = 0;
        drive(1, 16'h09C0);
        for (int i = 0; i < 5; i++) cyc();
        chk("sat_small", s_cnt, 3);
        chk("sat_wide", stall_count, 6);
        out_ready = 1; cyc();
        chk("sat_bubble", out_valid, 0);
        chk("sat_wide_after", stall_count, 7);
        cyc();
        chk("sat_add", opcode, 0);
        chk("sat_add_valid", out_valid, 1);

        // Mid-stream reset drops the instruction
        drive(1, 16'h14B7); cyc();
        rst_n = 0; drive(0, 16'h0000); cyc();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_stall", stall_count, 0);
        chk("mrst_sat", s_cnt, 0);
        rst_n = 1; cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage for the 16-bit custom processor. It sits between the instruction register (fetch) and the ALU/execute stage. It turns each accepted instruction into registered control lines and operand fields, and moves instructions with a valid/ready handshake on both sides. It also detects load-use hazards and inserts a single bubble, supports a synchronous flush from execute, and counts stall cycles.

## Interface
Parameters:
- INSTR_W, 16, instruction width.
- REG_AW, 3, register-address width.
- IMM_W, 6, immediate width; field is instr[INSTR_W-1 -: IMM_W].
- JUMP_W, 8, jump-address width; field is instr[4 +: JUMP_W].
- SHAMT_W, 3, shift-amount width; field is instr[INSTR_W-1 -: SHAMT_W].
- CNT_W, 16, stall-counter width.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- instr  in  INSTR_W  instruction from the IR.
- in_valid  in  1  instr is valid.
- in_ready  out  1  stage accepts instr this cycle.
- out_ready  in  1  execute accepts the stage output.
- out_valid  out  1  stage output holds a real instruction.
- flush  in  1  discard stage contents; block intake this cycle.
- opcode  out  4  instr[3:0].
- wreg_sig  out  REG_AW  destination field, instr[4 +: REG_AW].
- rreg_sig1  out  REG_AW  source-1 field, instr[4+REG_AW +: REG_AW].
- rreg_sig2  out  REG_AW  source-2 field, instr[4+2*REG_AW +: REG_AW].
- imm  out  IMM_W; jump_addr  out  JUMP_W; shamt  out  SHAMT_W.
- pc_select, alu_out_select, reg_write, rd_select, mul_flag  out  1 each.
- src2_select  out  2.
- stall_count  out  CNT_W  saturating count of hazard cycles.

## Operation
- Decode is applied to instr at capture; outputs come from the pipeline register.
- pc_select=1 iff opcode 9.
- src2_select = 1 for opcodes 5..8, 2 for opcodes 1..2, else 0.
- alu_out_select=1 iff opcode 7 (lw).
- rd_select=1 iff opcode 6 (li).
- mul_flag=1 iff opcode 10.
- reg_write=0 for opcode 8 (sw) and opcode 9 (jump); 1 otherwise.
- Field outputs are always driven from their bit slices regardless of opcode. No latches are permitted.
- reads_rs1 = opcode not in {6, 9}.
- reads_rs2 = opcode in {0, 3, 4, 8, 10..15}.
- hazard = out_valid && stage opcode==7 && in_valid && ((reads_rs1 && rreg_sig1(instr)==wreg_sig) || (reads_rs2 && rreg_sig2(instr)==wreg_sig)).
- in_ready = (!out_valid || out_ready) && !hazard && !flush. This is combinational.
- Capture: if in_valid && in_ready, the register loads the decoded instr and out_valid becomes 1 next cycle.
- Drain without capture: if out_valid && out_ready and nothing is captured, the register clears to a bubble (out_valid=0, all control outputs 0).
- Hold: if out_valid && !out_ready, all outputs are held unchanged.
- Hazard with out_ready=1: the lw drains and a bubble is loaded. Next cycle the hazard is false and instr is accepted, giving exactly one bubble.
- Flush: the register clears to a bubble next cycle and no capture happens that cycle. Priority is rst_n > flush > capture.
- stall_count increments each cycle in which hazard=1 and flush=0. It saturates at 2^CNT_W-1 and clears only on reset.

## Timing
- Latency is 1 cycle: an instr accepted at edge N appears on the outputs after edge N.
- Throughput is 1 instr/cycle when out_ready=1 and there is no hazard.
- Reset (rst_n=0 at an edge):
  - out_valid=0, all control, field and opcode outputs =0, stall_count=0.
  - in_ready=1 once rst_n=1 (stage empty, no hazard), provided flush=0.
- Reset mid-stream drops the held instruction. Upstream must re-present it.
- Simultaneous drain and capture in one cycle is a full-rate handoff with no bubble.
- Flush while out_valid && !out_ready still clears the stage.
- A hazard never blocks the lw itself from draining.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, then release -> all outputs 0, out_valid=0, in_ready=1, stall_count=0.
- Streaming with out_ready=1: send 0xA0A1 (sll), then 0x0A59 (jump) ->
  - cycle 1: opcode=1, src2_select=2, shamt=5, rreg_sig1=1, wreg_sig=2, reg_write=1.
  - cycle 2: pc_select=1, jump_addr=0xA5, reg_write=0.
- Load-use: 0x14B7 (lw r3, imm 5), then 0x09C0 (add r4, r3, r2) ->
  - one cycle with in_ready=0 and a bubble (out_valid=0).
  - add emitted on the following cycle.
  - stall_count=1.
- Backpressure: out_ready=0 for 3 cycles with 0x14B7 held -> outputs stable, in_ready=0; on release, the next instr is accepted the same cycle.
- Flush: flush=1 while 0x0A59 is in the stage and in_valid=1 -> next cycle out_valid=0, pc_select=0, incoming instr not captured.
- Saturation with CNT_W=2: force 5 hazard cycles -> stall_count stops at 3.
